uart_alu_interface: RTL

Byte-level frame controller between the UART receiver and transmitter. Collects a three-byte command frame (operand A, operand B, opcode) from the receiver's done-tick/data pair, drives registered operands and opcode to the combinational ALU, captures the result, and hands it to the UART transmitter with a start/done handshake. It also resynchronises on stalled frames and flags bytes lost while busy.

---
 rtl/uart_alu_pkg.sv | 33 +++
 rtl/uart_alu_interface_frame_timer.sv | 37 +++
 rtl/uart_alu_interface.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame controller: state encoding,
// default widths and the opcode values understood by the external ALU.
package uart_alu_pkg;

  localparam int D_BIT_DEF  = 8;
  localparam int OP_BIT_DEF = 6;

  localparam logic [2:0] ST_GET_A   = 3'd0;
  localparam logic [2:0] ST_GET_B   = 3'd1;
  localparam logic [2:0] ST_GET_OP  = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    GET_A   = ST_GET_A,
    GET_B   = ST_GET_B,
    GET_OP  = ST_GET_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_interface_frame_timer.sv
// Inter-byte watchdog: counts enabled cycles, saturates at the last count
// and flags expiry while enabled at that count.
module frame_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = i_enable && (count_q == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Frame controller: gathers A, B, opcode bytes from the UART receiver, feeds
// the external ALU, and hands the result to the transmitter.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int D_BIT       = D_BIT_DEF,
  parameter int OP_BIT      = OP_BIT_DEF,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_done_tick,
  input  logic [D_BIT-1:0]  i_rx_data,
  input  logic [D_BIT-1:0]  i_alu_result,
  input  logic              i_tx_done_tick,
  output logic [D_BIT-1:0]  o_data_a,
  output logic [D_BIT-1:0]  o_data_b,
  output logic [OP_BIT-1:0] o_op,
  output logic [D_BIT-1:0]  o_tx_data,
  output logic              o_tx_start,
  output logic              o_timeout,
  output logic              o_overrun
);

  state_t             state_q, state_d;
  logic [D_BIT-1:0]   data_a_q, data_a_d;
  logic [D_BIT-1:0]   data_b_q, data_b_d;
  logic [OP_BIT-1:0]  op_q, op_d;
  logic [D_BIT-1:0]   tx_data_q, tx_data_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic               timer_en;
  logic               timer_exp;

  // Timer runs only while a frame is partially received; anything else holds it at zero.
  assign timer_en = (state_q == GET_B) || (state_q == GET_OP);

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (accept || !timer_en),
    .i_enable (timer_en),
    .o_expire (timer_exp)
  );

  always_comb begin
    state_d   = state_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;
    timeout_d = 1'b0;
    accept    = 1'b0;
    case (state_q)
      GET_A: begin
        if (i_rx_done_tick) begin
          data_a_d = i_rx_data;
          accept   = 1'b1;
          state_d  = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done_tick) begin
          data_b_d = i_rx_data;
          accept   = 1'b1;
          state_d  = GET_OP;
        end else if (timer_exp) begin
          timeout_d = 1'b1;
          state_d   = GET_A;
        end
      end
      GET_OP: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[OP_BIT-1:0];
          accept  = 1'b1;
          state_d = EXEC;
        end else if (timer_exp) begin
          timeout_d = 1'b1;
          state_d   = GET_A;
        end
      end
      EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
        if (i_rx_done_tick) overrun_d = 1'b1;
      end
      SEND: begin
        state_d = WAIT_TX;
        if (i_rx_done_tick) overrun_d = 1'b1;
      end
      WAIT_TX: begin
        // A byte coinciding with the transmit-done tick starts the next frame.
        if (i_tx_done_tick) begin
          state_d = GET_A;
          if (i_rx_done_tick) begin
            data_a_d = i_rx_data;
            accept   = 1'b1;
            state_d  = GET_B;
          end
        end else if (i_rx_done_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= GET_A;
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == SEND);
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule
